// File: rtl/gpio_cmd_controller.sv
// GPIO command decoder: synchronises and debounces a 32-bit {payload, channel, opcode} word,
// executes each accepted command once and completes it with a request/acknowledge handshake.
module gpio_cmd_controller #(
    parameter int NCH        = 2,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16,
    parameter int DAC_W      = 14,
    parameter int STABLE_CYC = 2,
    parameter int PULSE_LEN  = 1
) (
    input  logic                    clk,
    input  logic                    RESET_in,
    input  logic [31:0]             SELECT_in,
    input  logic [NCH*DATA_W-1:0]   DATA_in,
    input  logic [NCH*CNT_W-1:0]    DATAcnt_in,
    output logic [DATA_W-1:0]       GPIO_out,
    output logic                    _RESET_out,
    output logic [NCH-1:0]          DATAread_out,
    output logic                    SLEAP_out,
    output logic [DAC_W-1:0]        ANALOG_out,
    output logic [NCH*DAC_W-1:0]    TRGLEVEL_out,
    output logic                    ACK_out,
    output logic                    ERR_out
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SC_W = $clog2(STABLE_CYC + 1);
    localparam int PL_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    localparam logic [7:0] OP_START = 8'h01;
    localparam logic [7:0] OP_INQ   = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h04;
    localparam logic [7:0] OP_STOP  = 8'h08;
    localparam logic [7:0] OP_DAC   = 8'h10;
    localparam logic [7:0] OP_TRG   = 8'h20;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_HOLD} state_e;

    logic [31:0]                  s1_q, s2_q;
    logic [SC_W-1:0]              stab_q, stab_d;
    logic                         stable;

    state_e                       state_q, state_d;
    logic [PL_W-1:0]              pcnt_q, pcnt_d;
    logic                         exec_read_q, exec_read_d;
    logic                         exec_start_q, exec_start_d;
    logic [CH_W-1:0]              cmd_ch_q, cmd_ch_d;
    logic                         sleap_q, sleap_d;
    logic [DAC_W-1:0]             analog_q, analog_d;
    logic [NCH-1:0][DAC_W-1:0]    trg_q, trg_d;
    logic                         err_q, err_d;
    logic                         rb_cnt_q, rb_cnt_d;
    logic [CH_W-1:0]              rb_ch_q, rb_ch_d;

    logic [7:0]                   op;
    logic [7:0]                   ch_raw;
    logic [DAC_W-1:0]             pl;
    logic                         cmd_ok;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge RESET_in) begin
        if (RESET_in) begin
            s1_q   <= '0;
            s2_q   <= '0;
            stab_q <= '0;
        end else begin
            s1_q   <= SELECT_in;
            s2_q   <= s1_q;
            stab_q <= stab_d;
        end
    end

    // Any change arriving at s2 restarts the stability window; otherwise count up and saturate.
    always_comb begin
        stab_d = stab_q;
        if (s1_q != s2_q)
            stab_d = '0;
        else if (!stable)
            stab_d = stab_q + 1'b1;
    end

    assign stable = (stab_q == SC_W'(STABLE_CYC));
    assign op     = s2_q[7:0];
    assign ch_raw = s2_q[15:8];
    assign pl     = s2_q[16 +: DAC_W];

    always_comb begin
        case (op)
            OP_START, OP_STOP, OP_DAC: cmd_ok = 1'b1;
            OP_INQ, OP_READ, OP_TRG:   cmd_ok = (ch_raw < 8'(NCH));
            default:                   cmd_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge RESET_in) begin
        if (RESET_in) begin
            state_q      <= ST_IDLE;
            pcnt_q       <= '0;
            exec_read_q  <= 1'b0;
            exec_start_q <= 1'b0;
            cmd_ch_q     <= '0;
            sleap_q      <= 1'b1;
            analog_q     <= '0;
            trg_q        <= '0;
            err_q        <= 1'b0;
            rb_cnt_q     <= 1'b0;
            rb_ch_q      <= '0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            exec_read_q  <= exec_read_d;
            exec_start_q <= exec_start_d;
            cmd_ch_q     <= cmd_ch_d;
            sleap_q      <= sleap_d;
            analog_q     <= analog_d;
            trg_q        <= trg_d;
            err_q        <= err_d;
            rb_cnt_q     <= rb_cnt_d;
            rb_ch_q      <= rb_ch_d;
        end
    end

    // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        exec_read_d  = exec_read_q;
        exec_start_d = exec_start_q;
        cmd_ch_d     = cmd_ch_q;
        sleap_d      = sleap_q;
        analog_d     = analog_q;
        trg_d        = trg_q;
        err_d        = err_q;
        rb_cnt_d     = rb_cnt_q;
        rb_ch_d      = rb_ch_q;

        unique case (state_q)
            ST_IDLE: begin
                if (stable && op != 8'h00) begin
                    // Register effects land on the same edge the EXEC strobes start.
                    state_d      = ST_EXEC;
                    pcnt_d       = '0;
                    exec_read_d  = cmd_ok && (op == OP_READ);
                    exec_start_d = (op == OP_START);
                    cmd_ch_d     = ch_raw[CH_W-1:0];
                    err_d        = !cmd_ok;
                    if (cmd_ok) begin
                        case (op)
                            OP_START: sleap_d = 1'b1;
                            OP_STOP:  sleap_d = 1'b0;
                            OP_DAC:   analog_d = pl;
                            OP_INQ: begin
                                rb_cnt_d = 1'b1;
                                rb_ch_d  = ch_raw[CH_W-1:0];
                            end
                            OP_READ: begin
                                rb_cnt_d = 1'b0;
                                rb_ch_d  = ch_raw[CH_W-1:0];
                            end
                            OP_TRG: begin
                                for (int k = 0; k < NCH; k++)
                                    if (ch_raw[CH_W-1:0] == CH_W'(k))
                                        trg_d[k] = pl;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_EXEC: begin
                if (pcnt_q == PL_W'(PULSE_LEN - 1))
                    state_d = ST_HOLD;
                else
                    pcnt_d = pcnt_q + 1'b1;
            end
            ST_HOLD: begin
                if (stable && op == 8'h00)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        DATAread_out = '0;
        for (int k = 0; k < NCH; k++)
            DATAread_out[k] = (state_q == ST_EXEC) && exec_read_q && (cmd_ch_q == CH_W'(k));
    end

    always_comb begin
        GPIO_out = '0;
        for (int k = 0; k < NCH; k++)
            if (rb_ch_q == CH_W'(k))
                GPIO_out = rb_cnt_q ? DATA_W'(DATAcnt_in[k*CNT_W +: CNT_W])
                                    : DATA_in[k*DATA_W +: DATA_W];
    end

    assign _RESET_out   = !((state_q == ST_EXEC) && exec_start_q);
    assign SLEAP_out    = sleap_q;
    assign ANALOG_out   = analog_q;
    assign TRGLEVEL_out = trg_q;
    assign ACK_out      = (state_q == ST_HOLD);
    assign ERR_out      = err_q;

endmodule

// File: tb/tb_gpio_cmd_controller.sv
// Self-checking bench for gpio_cmd_controller: directed handshake/latency cases plus randomized
// commands checked against a command-level model of the register file and readback selection.
module tb_gpio_cmd_controller;

    localparam int NCH    = 2;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int DAC_W  = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst, rst3;
    logic [31:0]             sel, sel3;
    logic [DATA_W-1:0]       dat [NCH];
    logic [CNT_W-1:0]        cnt [NCH];
    logic [NCH*DATA_W-1:0]   data_bus;
    logic [NCH*CNT_W-1:0]    cnt_bus;

    logic [DATA_W-1:0]       gpio, gpio3;
    logic                    fifo_rst_n, fifo_rst_n3;
    logic [NCH-1:0]          dread, dread3;
    logic                    sleap, sleap3;
    logic [DAC_W-1:0]        analog, analog3;
    logic [NCH*DAC_W-1:0]    trg, trg3;
    logic                    ack, ack3;
    logic                    err, err3;

    always_comb begin
        data_bus = '0;
        cnt_bus  = '0;
        for (int k = 0; k < NCH; k++) begin
            data_bus[k*DATA_W +: DATA_W] = dat[k];
            cnt_bus[k*CNT_W +: CNT_W]    = cnt[k];
        end
    end

    gpio_cmd_controller #(.NCH(NCH), .DATA_W(DATA_W), .CNT_W(CNT_W), .DAC_W(DAC_W),
                          .STABLE_CYC(2), .PULSE_LEN(1)) dut (
        .clk(clk), .RESET_in(rst), .SELECT_in(sel), .DATA_in(data_bus), .DATAcnt_in(cnt_bus),
        .GPIO_out(gpio), ._RESET_out(fifo_rst_n), .DATAread_out(dread), .SLEAP_out(sleap),
        .ANALOG_out(analog), .TRGLEVEL_out(trg), .ACK_out(ack), .ERR_out(err)
    );

    gpio_cmd_controller #(.NCH(NCH), .DATA_W(DATA_W), .CNT_W(CNT_W), .DAC_W(DAC_W),
                          .STABLE_CYC(2), .PULSE_LEN(3)) dut3 (
        .clk(clk), .RESET_in(rst3), .SELECT_in(sel3), .DATA_in(data_bus), .DATAcnt_in(cnt_bus),
        .GPIO_out(gpio3), ._RESET_out(fifo_rst_n3), .DATAread_out(dread3), .SLEAP_out(sleap3),
        .ANALOG_out(analog3), .TRGLEVEL_out(trg3), .ACK_out(ack3), .ERR_out(err3)
    );

    int tests_run = 0;
    int fails     = 0;

    // Command-level reference model
    logic             m_sleap;
    logic [DAC_W-1:0] m_analog;
    logic [DAC_W-1:0] m_trg [NCH];
    logic             m_err;
    logic             m_rb_cnt;
    int               m_rb_ch;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic cmd_valid(input logic [31:0] w);
        case (w[7:0])
            8'h01, 8'h08, 8'h10: return 1'b1;
            8'h02, 8'h04, 8'h20: return int'(w[15:8]) < NCH;
            default:             return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_sleap  = 1'b1;
        m_analog = '0;
        for (int k = 0; k < NCH; k++) m_trg[k] = '0;
        m_err    = 1'b0;
        m_rb_cnt = 1'b0;
        m_rb_ch  = 0;
    endtask

    task automatic model_apply(input logic [31:0] w);
        int ch;
        ch = int'(w[15:8]);
        if (!cmd_valid(w)) begin
            m_err = 1'b1;
        end else begin
            m_err = 1'b0;
            case (w[7:0])
                8'h01: m_sleap = 1'b1;
                8'h02: begin m_rb_cnt = 1'b1; m_rb_ch = ch; end
                8'h04: begin m_rb_cnt = 1'b0; m_rb_ch = ch; end
                8'h08: m_sleap = 1'b0;
                8'h10: m_analog = w[16 +: DAC_W];
                8'h20: m_trg[ch] = w[16 +: DAC_W];
                default: ;
            endcase
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_gpio();
        return m_rb_cnt ? DATA_W'(cnt[m_rb_ch]) : dat[m_rb_ch];
    endfunction

    function automatic logic [NCH*DAC_W-1:0] exp_trg();
        logic [NCH*DAC_W-1:0] v;
        for (int k = 0; k < NCH; k++) v[k*DAC_W +: DAC_W] = m_trg[k];
        return v;
    endfunction

    task automatic check_regs(input string tag);
        check({tag, ".sleap"},  sleap,      m_sleap);
        check({tag, ".analog"}, analog,     m_analog);
        check({tag, ".trg"},    trg,        exp_trg());
        check({tag, ".err"},    err,        m_err);
        check({tag, ".gpio"},   gpio,       exp_gpio());
        check({tag, ".rst_n"},  fifo_rst_n, 1'b1);
    endtask

    task automatic release_cmd(input string tag);
        int at;
        at = -1;
        @(negedge clk);
        sel = 32'h0;
        for (int k = 0; k < 20 && at < 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack === 1'b0) at = k;
        end
        check({tag, ".ack_fall"}, 64'(at), 64'd4);
    endtask

    // Drive one command word and follow it through EXEC to the ACK rise.
    task automatic do_cmd(input string tag, input logic [31:0] w, input bit rel);
        int             strobe_n, strobe_at, rlow_n, ack_at;
        logic [NCH-1:0] strobe_v, exp_strobe;
        strobe_n   = 0;
        strobe_at  = -1;
        rlow_n     = 0;
        ack_at     = -1;
        strobe_v   = '0;
        exp_strobe = (cmd_valid(w) && w[7:0] == 8'h04) ? (NCH'(1) << w[15:8]) : '0;
        @(negedge clk);
        sel = w;
        for (int k = 0; k < 20 && ack_at < 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (dread !== '0) begin
                strobe_n++;
                if (strobe_at < 0) strobe_at = k;
                strobe_v = dread;
            end
            if (fifo_rst_n === 1'b0) rlow_n++;
            if (ack === 1'b1) ack_at = k;
        end
        check({tag, ".ack_rise"},   64'(ack_at),   64'd5);
        check({tag, ".strobe_n"},   64'(strobe_n), (exp_strobe != '0) ? 64'd1 : 64'd0);
        if (exp_strobe != '0) begin
            check({tag, ".strobe_at"}, 64'(strobe_at), 64'd4);
            check({tag, ".strobe_v"},  strobe_v,       exp_strobe);
        end
        check({tag, ".rst_pulse"},  64'(rlow_n),   (w[7:0] == 8'h01) ? 64'd1 : 64'd0);
        model_apply(w);
        check_regs(tag);
        if (rel) release_cmd(tag);
    endtask

    logic [7:0] good_ops [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    logic [7:0] bad_ops  [5] = '{8'h03, 8'h05, 8'h40, 8'h80, 8'hFF};

    initial begin
        int             n_strobe, n_ack, found;
        logic [NCH-1:0] seen;
        logic [31:0]    w;

        rst  = 1'b1;
        rst3 = 1'b1;
        sel  = '0;
        sel3 = '0;
        for (int k = 0; k < NCH; k++) begin
            dat[k] = $urandom;
            cnt[k] = CNT_W'($urandom);
        end
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        rst3 = 1'b0;
        repeat (4) @(negedge clk);

        check("reset.rst_n",  fifo_rst_n, 1'b1);
        check("reset.dread",  dread,      '0);
        check("reset.ack",    ack,        1'b0);
        check_regs("reset");

        // Async reset in the middle of a 3-cycle READ strobe
        found = -1;
        seen  = '0;
        @(negedge clk);
        sel3 = 32'h0000_0104;
        for (int k = 0; k < 20 && found < 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (dread3 !== '0) begin found = k; seen = dread3; end
        end
        check("midreset.strobe_at", 64'(found), 64'd4);
        check("midreset.strobe_v",  seen,       2'b10);
        @(posedge clk);
        #1;
        rst3 = 1'b1;
        sel3 = '0;
        #1;
        check("midreset.dread", dread3, '0);
        check("midreset.ack",   ack3,   1'b0);
        @(negedge clk);
        rst3 = 1'b0;
        n_strobe = 0;
        n_ack    = 0;
        repeat (12) begin
            @(negedge clk);
            if (dread3 !== '0) n_strobe++;
            if (ack3 !== 1'b0) n_ack++;
        end
        check("midreset.post_strobes", 64'(n_strobe), 64'd0);
        check("midreset.post_ack",     64'(n_ack),    64'd0);

        // READ ch1 then live readback
        dat[1] = 32'hCAFE_0001;
        do_cmd("read_ch1", 32'h0000_0104, 1);
        check("read_ch1.gpio_lit", gpio, 32'hCAFE_0001);
        dat[1] = 32'h1357_9BDF;
        @(negedge clk);
        check("live_gpio", gpio, 32'h1357_9BDF);

        do_cmd("trg_ch1",   32'h1234_0120, 1);
        do_cmd("dac_max",   32'h3FFF_0010, 1);
        do_cmd("dac_trunc", 32'hFFFF_0010, 1);
        check("dac_trunc.lit", analog, 14'h3FFF);

        do_cmd("stop", 32'h0000_0008, 1);
        cnt[0] = 16'h00AB;
        do_cmd("inq_ch0", 32'h0000_0002, 1);
        check("inq_ch0.lit", gpio, 32'h0000_00AB);
        do_cmd("start", 32'h0000_0001, 1);

        do_cmd("bad_ch",  32'h0000_0504, 1);
        do_cmd("bad_op",  32'h0000_0003, 1);
        do_cmd("err_clr", 32'h0055_0010, 1);

        // Single-cycle glitch never reaches the stability threshold
        @(negedge clk);
        sel = 32'h0000_0004;
        @(negedge clk);
        sel = 32'h0;
        n_strobe = 0;
        n_ack    = 0;
        repeat (12) begin
            @(negedge clk);
            if (dread !== '0) n_strobe++;
            if (ack !== 1'b0) n_ack++;
        end
        check("glitch.strobes", 64'(n_strobe), 64'd0);
        check("glitch.ack",     64'(n_ack),    64'd0);

        // A new opcode during HOLD without an opcode-0 return is ignored
        dat[0] = 32'hA5A5_0000;
        cnt[1] = 16'h0077;
        do_cmd("hold_read", 32'h0000_0004, 0);
        @(negedge clk);
        sel = 32'h0000_0102;
        n_strobe = 0;
        n_ack    = 0;
        repeat (12) begin
            @(negedge clk);
            if (dread !== '0) n_strobe++;
            if (ack === 1'b1) n_ack++;
        end
        check("hold_swap.strobes", 64'(n_strobe), 64'd0);
        check("hold_swap.ack",     64'(n_ack),    64'd12);
        check_regs("hold_swap");
        release_cmd("hold_swap");

        // Randomized command stream
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < NCH; k++) begin
                dat[k] = $urandom;
                cnt[k] = CNT_W'($urandom);
            end
            w[31:16] = 16'($urandom);
            w[15:8]  = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 6) == 6)
                w[7:0] = bad_ops[$urandom_range(0, 4)];
            else
                w[7:0] = good_ops[$urandom_range(0, 5)];
            do_cmd("rand", w, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
